pc_trap_sequencer: RTL and testbench
====================================

# pc_trap_sequencer

Parametrised program-counter sequencer for the Dobby core; it succeeds the fixed 32-bit, two-interrupt PC logic. It owns the architectural PC and the boot, run and WFI-sleep state machine. It resolves branches and jumps with correct signed and unsigned compares, and vectors ECALL, illegal-instruction and NUM_IRQ prioritised interrupts. It sits between the decoder/register file and the fetch/memory arbiter, and feeds the trap PC to the CSR unit.

## Interface
- XLEN, 32, datapath and PC width
- NUM_IRQ, 4, number of interrupt lines (1..16)
- RESET_VEC, 'h8, PC after reset
- IRQ_BASE, 'h0, vector of IRQ 0
- IRQ_STRIDE, 4, byte spacing between IRQ vectors
- ILLEGAL_VEC, 'hC, illegal-instruction vector
- ECALL_VEC, 'h10, ECALL vector
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- boot_done  in  1  program RAM load complete
- stall  in  1  PC may not advance this cycle (fetch/load-store pending)
- dec_ecall, dec_mret, dec_wfi, illegal_instr, jump  in  1 each  decoder flags
- jump_type  in  4  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6 JALR, 7 JAL
- rs1_data, rs2_data  in  XLEN  register operands
- imm  in  XLEN  sign-extended immediate
- inst_size  in  2  instruction length in halfwords
- mepc_in  in  XLEN  return PC for MRET
- mstatus_mie  in  1  global interrupt enable
- irq_pending, irq_mask  in  NUM_IRQ  raw requests and per-line enables
- pc  out  XLEN  current PC
- run  out  1  high in RUN state
- sleeping  out  1  high in SLEEP state
- irq_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge
- trap_taken  out  1  one-cycle pulse on any trap or interrupt entry
- mepc_out  out  XLEN  PC saved for the CSR unit, valid with trap_taken

## Operation
- States: BOOT, RUN, SLEEP. Reset enters BOOT.
- BOOT: pc holds RESET_VEC and all requests are ignored. boot_done moves the block to RUN on the next edge; pc is unchanged.
- seq = pc + {inst_size,1'b0}. Branch target = pc + imm. JALR target = (rs1_data + imm) with bit 0 cleared. All arithmetic is modulo 2^XLEN.
- BLT/BGE compare signed; BLTU/BGEU compare unsigned. jump_type 8..15 behaves as not taken.
- eligible = irq_pending & irq_mask. The lowest set index wins.
- RUN priority per edge:
  1. stall: hold all state; no ack.
  2. Interrupt, when eligible != 0 and mstatus_mie: pc = IRQ_BASE + id*IRQ_STRIDE; mepc_out = pc; pulse irq_ack[id] and trap_taken.
  3. dec_ecall: pc = ECALL_VEC; mepc_out = pc; pulse trap_taken.
  4. dec_mret: pc = mepc_in.
  5. illegal_instr: pc = ILLEGAL_VEC; mepc_out = pc; pulse trap_taken.
  6. jump: taken target, else seq.
  7. dec_wfi: pc = seq, go to SLEEP.
  8. Otherwise: pc = seq.
- SLEEP: pc holds and stall is ignored. When eligible != 0:
  - with mstatus_mie, take the interrupt as in RUN (mepc_out = pc, i.e. the instruction after WFI) and go to RUN;
  - without mstatus_mie, go to RUN with pc unchanged.

## Timing
- Reset values: pc = RESET_VEC, run = 0, sleeping = 0, irq_ack = 0, trap_taken = 0, mepc_out = 0.
- Deassertion of resetn is synchronised externally; this block treats it as asynchronous.
- pc, irq_ack, trap_taken and mepc_out are registered. A redirect is visible on pc one cycle after the decoding edge.
- irq_ack and trap_taken are high for exactly one cycle and never assert during stall, BOOT or reset.
- If stall and an eligible interrupt occur together, the interrupt is taken on the first non-stalled edge, provided it is still eligible.
- Simultaneous interrupt and ECALL: the interrupt wins, and ECALL re-executes after return.
- Reset asserted mid-operation clears all state within the same cycle (asynchronous).
- Wrap-around: pc = 'hFFFF_FFFC with size 4 advances to 'h0.

## Test plan
- Reset then boot_done at cycle 5 -> pc = 'h8 throughout; run rises at cycle 6; after that, pc advances 'h8, 'hC, 'h10 with inst_size = 2.
- BLT with rs1 = 'hFFFF_FFFF, rs2 = 1, imm = 'h20, pc = 'h40 -> pc = 'h60. Same operands with BLTU -> pc = 'h44.
- irq_pending = 'b0110, mask = 'hF, mie = 1, pc = 'h100 -> pc = 'h4, irq_ack = 'b0010 for one cycle, mepc_out = 'h100.
- Interrupt with stall held for 3 cycles -> pc held and no ack during the stall; vector taken on the 4th edge.
- WFI at pc = 'h200, then irq 2 with mie = 0 -> pc = 'h204 and run resumes. Repeat with mie = 1 -> pc = 'h8, mepc_out = 'h204.
- JALR with rs1 = 'h1003, imm = 0 -> pc = 'h1002. Then MRET with mepc_in = 'h300 -> pc = 'h300.

Source files
------------

// File: rtl/pc_trap_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_trap_sequencer_if
//  Purpose  : Decoder-to-sequencer bundle. Carries decoded control flags,
//             branch/jump operands and the current instruction length.
//  Revision : 1.0  initial release
// ============================================================================
interface pc_trap_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            dec_ecall;
  logic            dec_mret;
  logic            dec_wfi;
  logic            illegal_instr;
  logic            jump;
  logic [3:0]      jump_type;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [1:0]      inst_size;

  // Decoder side drives the bundle
  modport master (
    output dec_ecall, dec_mret, dec_wfi, illegal_instr, jump, jump_type,
    output rs1_data, rs2_data, imm, inst_size
  );

  // Sequencer side consumes the bundle
  modport slave (
    input dec_ecall, dec_mret, dec_wfi, illegal_instr, jump, jump_type,
    input rs1_data, rs2_data, imm, inst_size
  );
endinterface
`default_nettype wire

// File: rtl/pc_trap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_trap_sequencer
//  Purpose  : Architectural PC owner for the Dobby core. Runs the boot, run
//             and WFI-sleep state machine, resolves branches and jumps, and
//             vectors ECALL, illegal-instruction and prioritised interrupts.
//  Revision : 1.0  initial release
// ============================================================================
module pc_trap_sequencer #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] RESET_VEC   = 'h8,
  parameter logic [XLEN-1:0] IRQ_BASE    = 'h0,
  parameter int unsigned     IRQ_STRIDE  = 4,
  parameter logic [XLEN-1:0] ILLEGAL_VEC = 'hC,
  parameter logic [XLEN-1:0] ECALL_VEC   = 'h10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               boot_done,
  input  logic               stall,
  pc_trap_sequencer_if.slave dec,
  input  logic [XLEN-1:0]    mepc_in,
  input  logic               mstatus_mie,
  input  logic [NUM_IRQ-1:0] irq_pending,
  input  logic [NUM_IRQ-1:0] irq_mask,
  output logic [XLEN-1:0]    pc,
  output logic               run,
  output logic               sleeping,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               trap_taken,
  output logic [XLEN-1:0]    mepc_out
);

  // Width of an interrupt index; a single line still needs one bit
  localparam int unsigned IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [3:0] JT_BEQ  = 4'd0;
  localparam logic [3:0] JT_BNE  = 4'd1;
  localparam logic [3:0] JT_BLT  = 4'd2;
  localparam logic [3:0] JT_BGE  = 4'd3;
  localparam logic [3:0] JT_BLTU = 4'd4;
  localparam logic [3:0] JT_BGEU = 4'd5;
  localparam logic [3:0] JT_JALR = 4'd6;
  localparam logic [3:0] JT_JAL  = 4'd7;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SLEEP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     mepc_q, mepc_d;
  logic [NUM_IRQ-1:0]  irq_ack_q, irq_ack_d;
  logic                trap_q, trap_d;
  logic                run_q, run_d;
  logic                sleep_q, sleep_d;

  logic [XLEN-1:0]     seq_pc;
  logic [XLEN-1:0]     branch_tgt;
  logic [XLEN-1:0]     jalr_sum;
  logic [XLEN-1:0]     jalr_tgt;
  logic [XLEN-1:0]     jump_pc;

  logic [NUM_IRQ-1:0]  eligible;
  logic [NUM_IRQ-1:0]  irq_onehot;
  logic [IDW-1:0]      irq_id;
  logic [XLEN-1:0]     irq_vec;
  logic                irq_take;

  // Sequential, branch and JALR target arithmetic (all modulo 2^XLEN)
  always_comb begin
    seq_pc     = pc_q + XLEN'({dec.inst_size, 1'b0});
    branch_tgt = pc_q + dec.imm;
    jalr_sum   = dec.rs1_data + dec.imm;
    jalr_tgt   = {jalr_sum[XLEN-1:1], 1'b0};
  end

  // Branch/jump resolution; reserved encodings fall through to seq
  always_comb begin
    jump_pc = seq_pc;
    case (dec.jump_type)
      JT_BEQ:  if (dec.rs1_data == dec.rs2_data) jump_pc = branch_tgt;
      JT_BNE:  if (dec.rs1_data != dec.rs2_data) jump_pc = branch_tgt;
      JT_BLT:  if ($signed(dec.rs1_data) <  $signed(dec.rs2_data)) jump_pc = branch_tgt;
      JT_BGE:  if ($signed(dec.rs1_data) >= $signed(dec.rs2_data)) jump_pc = branch_tgt;
      JT_BLTU: if (dec.rs1_data <  dec.rs2_data) jump_pc = branch_tgt;
      JT_BGEU: if (dec.rs1_data >= dec.rs2_data) jump_pc = branch_tgt;
      JT_JALR: jump_pc = jalr_tgt;
      JT_JAL:  jump_pc = branch_tgt;
      default: jump_pc = seq_pc;
    endcase
  end

  // Interrupt arbitration: lowest eligible index wins
  always_comb begin
    eligible   = irq_pending & irq_mask;
    irq_onehot = eligible & (~eligible + NUM_IRQ'(1));
    irq_id     = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) irq_id = IDW'(i);
    end
    irq_vec  = IRQ_BASE + (XLEN'(irq_id) * XLEN'(IRQ_STRIDE));
    irq_take = (|eligible) && mstatus_mie;
  end

  // Next-state and next-output computation for the boot/run/sleep machine
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mepc_d    = mepc_q;
    irq_ack_d = '0;
    trap_d    = 1'b0;

    case (state_q)
      ST_BOOT: begin
        // PC parked on the reset vector; every request ignored
        if (boot_done) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (stall) begin
          // hold everything; pending interrupt retried on next free edge
        end else if (irq_take) begin
          pc_d      = irq_vec;
          mepc_d    = pc_q;
          irq_ack_d = irq_onehot;
          trap_d    = 1'b1;
        end else if (dec.dec_ecall) begin
          pc_d   = ECALL_VEC;
          mepc_d = pc_q;
          trap_d = 1'b1;
        end else if (dec.dec_mret) begin
          pc_d = mepc_in;
        end else if (dec.illegal_instr) begin
          pc_d   = ILLEGAL_VEC;
          mepc_d = pc_q;
          trap_d = 1'b1;
        end else if (dec.jump) begin
          pc_d = jump_pc;
        end else if (dec.dec_wfi) begin
          pc_d    = seq_pc;
          state_d = ST_SLEEP;
        end else begin
          pc_d = seq_pc;
        end
      end

      ST_SLEEP: begin
        // pc already points past the WFI; stall has no meaning here
        if (|eligible) begin
          state_d = ST_RUN;
          if (mstatus_mie) begin
            pc_d      = irq_vec;
            mepc_d    = pc_q;
            irq_ack_d = irq_onehot;
            trap_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    run_d   = (state_d == ST_RUN);
    sleep_d = (state_d == ST_SLEEP);
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_VEC;
      mepc_q    <= '0;
      irq_ack_q <= '0;
      trap_q    <= 1'b0;
      run_q     <= 1'b0;
      sleep_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mepc_q    <= mepc_d;
      irq_ack_q <= irq_ack_d;
      trap_q    <= trap_d;
      run_q     <= run_d;
      sleep_q   <= sleep_d;
    end
  end

  assign pc         = pc_q;
  assign run        = run_q;
  assign sleeping   = sleep_q;
  assign irq_ack    = irq_ack_q;
  assign trap_taken = trap_q;
  assign mepc_out   = mepc_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_trap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_trap_sequencer
//  Purpose  : Directed self-checking bench for pc_trap_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_trap_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        boot_done;
  logic        stall;
  logic [31:0] mepc_in;
  logic        mstatus_mie;
  logic [3:0]  irq_pending;
  logic [3:0]  irq_mask;
  logic [31:0] pc;
  logic        run;
  logic        sleeping;
  logic [3:0]  irq_ack;
  logic        trap_taken;
  logic [31:0] mepc_out;

  int n_checks = 0;
  int n_fail   = 0;

  pc_trap_sequencer_if #(.XLEN(32)) dec_if ();

  pc_trap_sequencer dut (
    .clk         (clk),
    .resetn      (resetn),
    .boot_done   (boot_done),
    .stall       (stall),
    .dec         (dec_if.slave),
    .mepc_in     (mepc_in),
    .mstatus_mie (mstatus_mie),
    .irq_pending (irq_pending),
    .irq_mask    (irq_mask),
    .pc          (pc),
    .run         (run),
    .sleeping    (sleeping),
    .irq_ack     (irq_ack),
    .trap_taken  (trap_taken),
    .mepc_out    (mepc_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1ns before inputs change or outputs are checked
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [3:0] jt, input logic [31:0] im);
    dec_if.jump      = 1'b1;
    dec_if.jump_type = jt;
    dec_if.imm       = im;
    step();
    dec_if.jump      = 1'b0;
  endtask

  initial begin
    resetn               = 1'b0;
    boot_done            = 1'b0;
    stall                = 1'b0;
    mepc_in              = '0;
    mstatus_mie          = 1'b0;
    irq_pending          = '0;
    irq_mask             = '0;
    dec_if.dec_ecall     = 1'b0;
    dec_if.dec_mret      = 1'b0;
    dec_if.dec_wfi       = 1'b0;
    dec_if.illegal_instr = 1'b0;
    dec_if.jump          = 1'b0;
    dec_if.jump_type     = '0;
    dec_if.rs1_data      = '0;
    dec_if.rs2_data      = '0;
    dec_if.imm           = '0;
    dec_if.inst_size     = 2'd2;

    repeat (2) step();
    check_eq("rst_pc",    pc,         32'h8);
    check_eq("rst_run",   run,        1'b0);
    check_eq("rst_sleep", sleeping,   1'b0);
    check_eq("rst_ack",   irq_ack,    4'h0);
    check_eq("rst_trap",  trap_taken, 1'b0);
    check_eq("rst_mepc",  mepc_out,   32'h0);
    resetn = 1'b1;

    // BOOT ignores every request
    irq_pending = 4'b0001; irq_mask = 4'hF; mstatus_mie = 1'b1;
    dec_if.dec_ecall = 1'b1; dec_if.jump = 1'b1; dec_if.jump_type = 4'd7; dec_if.imm = 32'h40;
    step();
    check_eq("boot_pc",   pc,         32'h8);
    check_eq("boot_ack",  irq_ack,    4'h0);
    check_eq("boot_trap", trap_taken, 1'b0);
    check_eq("boot_run",  run,        1'b0);
    step();
    check_eq("boot_pc2",  pc,         32'h8);
    irq_pending = '0; dec_if.dec_ecall = 1'b0; dec_if.jump = 1'b0;

    boot_done = 1'b1;
    step();
    check_eq("boot_run_rise", run, 1'b1);
    check_eq("boot_pc_keep",  pc,  32'h8);
    boot_done = 1'b0;
    step(); check_eq("seq_c",  pc, 32'hC);
    step(); check_eq("seq_10", pc, 32'h10);

    // Branch compares
    do_jump(4'd7, 32'h30);             check_eq("jal_40",      pc, 32'h40);
    dec_if.rs1_data = 32'hFFFF_FFFF; dec_if.rs2_data = 32'h1;
    do_jump(4'd2, 32'h20);             check_eq("blt_taken",   pc, 32'h60);
    do_jump(4'd7, 32'hFFFF_FFE0);      check_eq("jal_back_40", pc, 32'h40);
    do_jump(4'd4, 32'h20);             check_eq("bltu_not",    pc, 32'h44);
    do_jump(4'd5, 32'h20);             check_eq("bgeu_taken",  pc, 32'h64);
    do_jump(4'd3, 32'h20);             check_eq("bge_not",     pc, 32'h68);
    do_jump(4'd0, 32'h20);             check_eq("beq_not",     pc, 32'h6C);
    do_jump(4'd9, 32'h20);             check_eq("jt_reserved", pc, 32'h70);
    do_jump(4'd7, 32'h90);             check_eq("jal_100",     pc, 32'h100);

    // Interrupt priority: lowest eligible id
    irq_pending = 4'b0110; mstatus_mie = 1'b1;
    step();
    check_eq("irq1_pc",   pc,         32'h4);
    check_eq("irq1_ack",  irq_ack,    4'b0010);
    check_eq("irq1_trap", trap_taken, 1'b1);
    check_eq("irq1_mepc", mepc_out,   32'h100);
    irq_pending = '0;
    step();
    check_eq("irq1_ack_off",  irq_ack,    4'h0);
    check_eq("irq1_trap_off", trap_taken, 1'b0);
    check_eq("irq1_next_pc",  pc,         32'h8);

    // Interrupt held off by stall
    stall = 1'b1; irq_pending = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_pc",   pc,         32'h8);
      check_eq("stall_ack",  irq_ack,    4'h0);
      check_eq("stall_trap", trap_taken, 1'b0);
    end
    stall = 1'b0;
    step();
    check_eq("stall_irq_pc",   pc,       32'h0);
    check_eq("stall_irq_ack",  irq_ack,  4'b0001);
    check_eq("stall_irq_mepc", mepc_out, 32'h8);
    irq_pending = '0;

    // WFI woken with interrupts disabled
    do_jump(4'd7, 32'h200);            check_eq("jal_200", pc, 32'h200);
    dec_if.dec_wfi = 1'b1;
    step();
    check_eq("wfi_pc",    pc,       32'h204);
    check_eq("wfi_sleep", sleeping, 1'b1);
    check_eq("wfi_run",   run,      1'b0);
    dec_if.dec_wfi = 1'b0; stall = 1'b1;
    step();
    check_eq("sleep_hold_pc", pc,       32'h204);
    check_eq("sleep_hold",    sleeping, 1'b1);
    stall = 1'b0; mstatus_mie = 1'b0; irq_pending = 4'b0100;
    step();
    check_eq("wake_nomie_pc",    pc,         32'h204);
    check_eq("wake_nomie_run",   run,        1'b1);
    check_eq("wake_nomie_sleep", sleeping,   1'b0);
    check_eq("wake_nomie_ack",   irq_ack,    4'h0);
    check_eq("wake_nomie_trap",  trap_taken, 1'b0);
    irq_pending = '0; mstatus_mie = 1'b1;

    // WFI woken with interrupts enabled
    do_jump(4'd7, 32'hFFFF_FFFC);      check_eq("jal_200b", pc, 32'h200);
    dec_if.dec_wfi = 1'b1;
    step();
    check_eq("wfi2_sleep", sleeping, 1'b1);
    dec_if.dec_wfi = 1'b0; irq_pending = 4'b0100;
    step();
    check_eq("wake_mie_pc",   pc,       32'h8);
    check_eq("wake_mie_mepc", mepc_out, 32'h204);
    check_eq("wake_mie_ack",  irq_ack,  4'b0100);
    check_eq("wake_mie_run",  run,      1'b1);
    irq_pending = '0;

    // JALR clears bit 0, then MRET
    dec_if.rs1_data = 32'h1003;
    do_jump(4'd6, 32'h0);              check_eq("jalr_pc", pc, 32'h1002);
    dec_if.dec_mret = 1'b1; mepc_in = 32'h300;
    step();
    check_eq("mret_pc", pc, 32'h300);
    dec_if.dec_mret = 1'b0;

    // Interrupt beats ECALL; ECALL then taken on its own
    dec_if.dec_ecall = 1'b1; irq_pending = 4'b1000;
    step();
    check_eq("irq_vs_ecall_pc",   pc,       32'hC);
    check_eq("irq_vs_ecall_mepc", mepc_out, 32'h300);
    check_eq("irq_vs_ecall_ack",  irq_ack,  4'b1000);
    irq_pending = '0;
    step();
    check_eq("ecall_pc",   pc,         32'h10);
    check_eq("ecall_mepc", mepc_out,   32'hC);
    check_eq("ecall_trap", trap_taken, 1'b1);
    check_eq("ecall_ack",  irq_ack,    4'h0);
    dec_if.dec_ecall = 1'b0;

    dec_if.illegal_instr = 1'b1;
    step();
    check_eq("illegal_pc",   pc,         32'hC);
    check_eq("illegal_mepc", mepc_out,   32'h10);
    check_eq("illegal_trap", trap_taken, 1'b1);
    dec_if.illegal_instr = 1'b0;

    // Masked request is not eligible
    irq_pending = 4'b0001; irq_mask = 4'h0;
    step();
    check_eq("masked_pc",   pc,         32'h10);
    check_eq("masked_ack",  irq_ack,    4'h0);
    check_eq("masked_trap", trap_taken, 1'b0);
    irq_pending = '0; irq_mask = 4'hF;

    // Wrap-around
    do_jump(4'd7, 32'hFFFF_FFEC);      check_eq("jal_top", pc, 32'hFFFF_FFFC);
    step();                            check_eq("wrap_pc", pc, 32'h0);
    step();                            check_eq("post_wrap_pc", pc, 32'h4);

    // Asynchronous reset between edges
    #3 resetn = 1'b0;
    #1;
    check_eq("async_rst_pc",   pc,       32'h8);
    check_eq("async_rst_run",  run,      1'b0);
    check_eq("async_rst_mepc", mepc_out, 32'h0);
    resetn = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
